// File: rtl/sfq_nott_driver_if.sv
// Bit-handshake and SFQ toggle lines between a bit source and the clocked-inverter driver.
interface sfq_nott_driver_if;
    logic       in_valid;
    logic       in_data;
    logic       in_ready;
    logic       sfq_a;
    logic       sfq_clk;
    logic       sfq_q;
    logic       exp_q;
    logic       busy;
    logic       err_flag;
    logic [7:0] err_count;

    modport master (
        output in_valid, in_data, sfq_q,
        input  in_ready, sfq_a, sfq_clk, exp_q, busy, err_flag, err_count
    );

    modport slave (
        input  in_valid, in_data, sfq_q,
        output in_ready, sfq_a, sfq_clk, exp_q, busy, err_flag, err_count
    );
endinterface

// File: rtl/sfq_nott_driver.sv
// Toggle-encoded driver for an SFQ clocked inverter with fixed data-to-clock spacing.
// Optional output checking is built when NOTT_DRV_CHECK_EN is defined.
module sfq_nott_driver #(
    parameter int unsigned GAP_A_CLK   = 2,
    parameter int unsigned GAP_CLK_CLK = 3
) (
    input  logic              clk,
    input  logic              rst,
    sfq_nott_driver_if.slave  bus
);
    localparam logic [7:0] GAP_A  = 8'(GAP_A_CLK);
    localparam logic [7:0] GAP_CC = 8'(GAP_CLK_CLK);

    typedef enum logic [1:0] {IDLE, WAIT_AC, WAIT_CC} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       bit_q, bit_nxt;
    logic       a_reg, clk_reg, exp_reg;
    logic       a_tgl, clk_tgl, cmp_en;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_q;
        a_tgl     = 1'b0;
        clk_tgl   = 1'b0;
        cmp_en    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    bit_nxt   = bus.in_data;
                    cnt_nxt   = GAP_A;
                    a_tgl     = bus.in_data;
                    state_nxt = WAIT_AC;
                end
            end
            WAIT_AC: begin
                if (cnt == 8'd1) begin
                    clk_tgl   = 1'b1;
                    cnt_nxt   = GAP_CC;
                    state_nxt = WAIT_CC;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            WAIT_CC: begin
                if (cnt == 8'd1) begin
                    cmp_en    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_q   <= 1'b0;
            a_reg   <= 1'b0;
            clk_reg <= 1'b0;
            exp_reg <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_q   <= bit_nxt;
            a_reg   <= a_reg ^ a_tgl;
            clk_reg <= clk_reg ^ clk_tgl;
            // Inverter semantics: only an unpulsed clock produces an output pulse.
            exp_reg <= exp_reg ^ (clk_tgl & ~bit_q);
        end
    end

`ifdef NOTT_DRV_CHECK_EN
    logic       err_reg;
    logic [7:0] cnt_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
            cnt_err <= '0;
        end else if (cmp_en && (bus.sfq_q != exp_reg)) begin
            err_reg <= 1'b1;
            if (cnt_err != 8'hFF) cnt_err <= cnt_err + 8'd1;
        end
    end

    assign bus.err_flag  = err_reg;
    assign bus.err_count = cnt_err;
`else
    assign bus.err_flag  = 1'b0;
    assign bus.err_count = '0;
`endif

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.sfq_a    = a_reg;
    assign bus.sfq_clk  = clk_reg;
    assign bus.exp_q    = exp_reg;
endmodule

// File: tb/tb_sfq_nott_driver.sv
// Scoreboard bench for sfq_nott_driver: stimulus queues expected toggle/ready events, a monitor checks them.
module tb_sfq_nott_driver;
    localparam int GA     = 2;
    localparam int GC     = 3;
    localparam int PERIOD = GA + GC + 1;

    typedef struct { int cyc; logic expq; } clk_exp_t;
    typedef struct { int cyc; int ecnt; logic eflag; } rdy_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    logic rst_edge = 1'b1;
    int   total = 0;
    int   bad = 0;

    int       a_q[$];
    clk_exp_t c_q[$];
    rdy_exp_t r_q[$];

    logic model_exp = 1'b0;
    int   model_err = 0;
    logic model_flag = 1'b0;
    bit   q_follow = 1'b1;
    int   last_t = 0;

    sfq_nott_driver_if dif();
    sfq_nott_driver_if dif2();

    sfq_nott_driver #(.GAP_A_CLK(GA), .GAP_CLK_CLK(GC)) dut (.clk(clk), .rst(rst), .bus(dif));
    sfq_nott_driver #(.GAP_A_CLK(1), .GAP_CLK_CLK(2)) dut2 (.clk(clk), .rst(rst), .bus(dif2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops an expectation whenever the DUT shows an output event.
    initial begin
        logic pa, pc, pr;
        int ea;
        clk_exp_t ec;
        rdy_exp_t er;
        pa = 1'b0; pc = 1'b0; pr = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_edge) begin
                if (dif.sfq_a != pa && dif.sfq_clk != pc)
                    chk("a_clk_same_edge", 1, 0);
                if (dif.sfq_a != pa) begin
                    if (a_q.size() == 0) chk("a_unexpected", 1, 0);
                    else begin ea = a_q.pop_front(); chk("a_time", cyc, ea); end
                end
                if (dif.sfq_clk != pc) begin
                    if (c_q.size() == 0) chk("clk_unexpected", 1, 0);
                    else begin
                        ec = c_q.pop_front();
                        chk("clk_time", cyc, ec.cyc);
                        chk("exp_q", int'(dif.exp_q), int'(ec.expq));
                    end
                end
                if (dif.in_ready && !pr) begin
                    if (r_q.size() == 0) chk("ready_unexpected", 1, 0);
                    else begin
                        er = r_q.pop_front();
                        chk("ready_time", cyc, er.cyc);
                        chk("err_count", int'(dif.err_count), er.ecnt);
                        chk("err_flag", int'(dif.err_flag), int'(er.eflag));
                    end
                end
            end
            pa = dif.sfq_a; pc = dif.sfq_clk; pr = dif.in_ready;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(dif.in_ready), 1);
        chk("rst_busy", int'(dif.busy), 0);
        chk("rst_a", int'(dif.sfq_a), 0);
        chk("rst_clk", int'(dif.sfq_clk), 0);
        chk("rst_exp_q", int'(dif.exp_q), 0);
        chk("rst_err_flag", int'(dif.err_flag), 0);
        chk("rst_err_count", int'(dif.err_count), 0);
        rst = 1'b0;
        model_exp = 1'b0; model_err = 0; model_flag = 1'b0;
    endtask

    // Offer one bit; called and returns on a falling edge.
    task automatic send(input logic b, input bit keep, input bit full, input bit pchk);
        int n = 0;
        int t;
        dif.in_valid = 1'b1;
        dif.in_data  = b;
        while (!dif.in_ready && n < 40) begin @(negedge clk); n++; end
        if (!dif.in_ready) begin
            chk("accept_timeout", 0, 1);
            dif.in_valid = 1'b0;
            return;
        end
        t = cyc + 1;
        if (pchk) chk("period", t - last_t, PERIOD);
        last_t = t;
        if (b) a_q.push_back(t);
        if (full) begin
            model_exp = model_exp ^ ~b;
            if (q_follow) dif.sfq_q = model_exp;
`ifdef NOTT_DRV_CHECK_EN
            if (dif.sfq_q != model_exp) begin
                model_flag = 1'b1;
                if (model_err < 255) model_err++;
            end
`endif
            c_q.push_back('{t + GA, model_exp});
            r_q.push_back('{t + GA + GC, model_err, model_flag});
        end
        @(negedge clk);
        if (!keep) dif.in_valid = 1'b0;
    endtask

    initial begin
        int n, t, t2;
        logic [3:0] stream;
        dif.in_valid = 1'b0; dif.in_data = 1'b0; dif.sfq_q = 1'b0;
        dif2.in_valid = 1'b0; dif2.in_data = 1'b0; dif2.sfq_q = 1'b0;
        @(negedge clk);
        do_reset();

        // Single bits: 1 then 0.
        send(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        send(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) @(negedge clk);

        // Back-to-back stream 0,0,1,0 -> exp_q 1,0,0,1.
        do_reset();
        stream = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            logic sb;
            sb = stream[i];
            send(sb, 1'b1, 1'b1, i != 0);
        end
        dif.in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // sfq_q stuck at 0.
        do_reset();
        q_follow = 1'b0;
        dif.sfq_q = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 1'b1, i != 0);
        dif.in_valid = 1'b0;
        repeat (8) @(negedge clk);
`ifdef NOTT_DRV_CHECK_EN
        chk("err_count_3bits", int'(dif.err_count), 2);
        chk("err_flag_3bits", int'(dif.err_flag), 1);
`else
        chk("err_count_3bits", int'(dif.err_count), 0);
        chk("err_flag_3bits", int'(dif.err_flag), 0);
`endif
        for (int i = 0; i < 600; i++) send(1'b0, 1'b1, 1'b1, i != 0);
        dif.in_valid = 1'b0;
        repeat (8) @(negedge clk);
`ifdef NOTT_DRV_CHECK_EN
        chk("err_count_sat", int'(dif.err_count), 255);
`else
        chk("err_count_sat", int'(dif.err_count), 0);
`endif

        // Reset while waiting for the clock toggle abandons the bit.
        q_follow = 1'b1;
        do_reset();
        send(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_a", int'(dif.sfq_a), 0);
        chk("abort_clk", int'(dif.sfq_clk), 0);
        chk("abort_exp_q", int'(dif.exp_q), 0);
        chk("abort_ready", int'(dif.in_ready), 1);
        chk("abort_err_count", int'(dif.err_count), 0);
        rst = 1'b0;
        model_exp = 1'b0; model_err = 0; model_flag = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_clk", int'(dif.sfq_clk), 0);

        // Minimum gaps on the second instance.
        dif2.in_valid = 1'b1;
        dif2.in_data  = 1'b0;
        n = 0;
        while (!dif2.in_ready && n < 20) begin @(negedge clk); n++; end
        t = cyc + 1;
        @(negedge clk);
        n = 0;
        while (dif2.sfq_clk == 1'b0 && n < 20) begin @(negedge clk); n++; end
        chk("g1_clk_time", cyc, t + 1);
        chk("g1_exp_q", int'(dif2.exp_q), 1);
        n = 0;
        while (!dif2.in_ready && n < 20) begin @(negedge clk); n++; end
        chk("g1_ready_time", cyc, t + 3);
        t2 = cyc + 1;
        chk("g1_period", t2 - t, 4);
        @(negedge clk);
        dif2.in_valid = 1'b0;
        n = 0;
        while (dif2.sfq_clk == 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("g1_clk2_time", cyc, t2 + 1);
        chk("g1_exp_q2", int'(dif2.exp_q), 0);

        repeat (4) @(negedge clk);
        chk("a_q_left", a_q.size(), 0);
        chk("c_q_left", c_q.size(), 0);
        chk("r_q_left", r_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sfq_nott_driver.md
SFQ_NOTT_DRIVER -- requirements
Module: sfq_nott_driver

Interface
REQ-001 Parameter GAP_A_CLK, default 2: system cycles from the data toggle to the SFQ clock toggle; legal range 1..255.
REQ-002 Parameter GAP_CLK_CLK, default 3: system cycles from the SFQ clock toggle to the return to IDLE; legal range 2..255.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  bit offered.
REQ-006 in_data  input  1  bit to apply: 1 = send data pulse before clock, 0 = clock only.
REQ-007 in_ready  output  1  driver accepts a bit this cycle.
REQ-008 sfq_a  output  1  toggle-encoded data line to the downstream clocked inverter; each transition is one pulse.
REQ-009 sfq_clk  output  1  toggle-encoded clock line to the clocked inverter.
REQ-010 sfq_q  input  1  toggle-encoded inverter output returned for checking.
REQ-011 exp_q  output  1  expected level of sfq_q.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 err_flag  output  1  sticky mismatch indicator.
REQ-014 err_count  output  8  mismatch count, saturating.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT_AC and WAIT_CC; in_ready = (state == IDLE); busy = !in_ready.
REQ-016 Accept SHALL occur at edge T where in_valid & in_ready; at T the driver latches in_data, loads an 8-bit counter with GAP_A_CLK and enters WAIT_AC.
REQ-017 If the latched bit is 1, sfq_a SHALL toggle at edge T; if 0, sfq_a SHALL hold.
REQ-018 In WAIT_AC the counter SHALL decrement each edge; at the edge where it equals 1, sfq_clk SHALL toggle, the counter SHALL load GAP_CLK_CLK and the state SHALL become WAIT_CC.
REQ-019 sfq_clk therefore SHALL toggle at edge T+GAP_A_CLK for both bit values; latency is constant.
REQ-020 exp_q SHALL toggle at the sfq_clk toggle edge only when the latched bit is 0 (inverter semantics: an unpulsed clock emits an output pulse; a data pulse suppresses it).
REQ-021 In WAIT_CC the counter SHALL decrement each edge; at the edge where it equals 1 the driver SHALL compare sfq_q with exp_q and return to IDLE, at edge T+GAP_A_CLK+GAP_CLK_CLK.
REQ-022 Sustained throughput SHALL be one bit per GAP_A_CLK+GAP_CLK_CLK+1 cycles (6 cycles at the defaults).
REQ-023 in_valid and in_data SHALL be ignored outside IDLE; no bit is ever lost or duplicated.
REQ-024 The driver SHALL never toggle sfq_a and sfq_clk on the same edge, and never toggle sfq_a within GAP_CLK_CLK cycles after an sfq_clk toggle.

Reset
REQ-025 With rst high at an edge: state = IDLE, counter = 0, sfq_a = 0, sfq_clk = 0, exp_q = 0, err_flag = 0, err_count = 0; in_ready reads 1 in the following cycle.
REQ-026 Reset mid-operation SHALL abandon the in-flight bit with no further toggles, and no compare SHALL occur for it.
REQ-027 Clearing sfq_a or sfq_clk from 1 to 0 may present a pulse downstream; the downstream cell SHALL be reset concurrently.

Configuration
REQ-028 Macro NOTT_DRV_CHECK_EN: when defined, the compare of REQ-021 operates as follows.
REQ-029 On a mismatch, err_flag SHALL set and err_count SHALL increment, saturating at 255.
REQ-030 When NOTT_DRV_CHECK_EN is undefined, sfq_q SHALL be unused, and err_flag and err_count SHALL be tied to 0.
REQ-031 exp_q and all stimulus timing SHALL be identical with and without NOTT_DRV_CHECK_EN.

Verification
REQ-032 Reset then offer bit 1 at defaults -> sfq_a toggles at T, sfq_clk at T+2, exp_q stays 0, in_ready returns at T+5.
REQ-033 Offer bit 0 -> sfq_a holds, sfq_clk toggles at T+2, exp_q goes 1.
REQ-034 Stream 0,0,1,0 with in_valid held high -> accepts spaced 6 cycles apart; exp_q sequence 1,0,0,1; four sfq_clk toggles.
REQ-035 With CHECK_EN, feed sfq_q stuck at 0 for bits 0,0,0 -> err_count = 2, err_flag = 1; after 300 mismatches err_count = 255.
REQ-036 Assert rst during WAIT_AC after a bit-1 accept -> no sfq_clk toggle, all outputs 0 next cycle, err_count unchanged at 0.
REQ-037 GAP_A_CLK=1, GAP_CLK_CLK=2 -> sfq_clk toggles at T+1, in_ready at T+3, period 4 cycles.
